// File: rtl/cnt_run_ctrl.sv
// rtl/cnt_run_ctrl.sv - run/pause/clear/direction controller for the seconds counter
// Optional tick limit with DONE state: define CNT_AUTOSTOP_EN.
module cnt_run_ctrl #(
    parameter int FREQUENCY   = 50 * 10**6,
    parameter int DEBOUNCE_MS = 20,
    parameter int MAX_TICKS   = 100
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btn_ss_n,
    input  logic       btn_clr_n,
    input  logic       btn_dir_n,
    input  logic       one_sec_flag,
    output logic       tick_en_out,
    output logic       clr_out,
    output logic       dir_out,
    output logic [1:0] state_out
);

    localparam int DEB_CYCLES = FREQUENCY / 1000 * DEBOUNCE_MS;
    localparam int CW         = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;
    localparam int BTN_DIR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    logic [2:0]    btn_raw;
    logic [2:0]    sync_a;
    logic [2:0]    sync_b;
    logic [2:0]    deb_lvl;
    logic [2:0]    press;
    logic [CW-1:0] deb_cnt [3];

    state_t state_q;
    state_t state_d;
    logic   tick_d;
    logic   last_tick;

    assign btn_raw = {btn_dir_n, btn_clr_n, btn_ss_n};

    // Buttons idle high; a press event is registered on the edge the debounced level falls.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_a  <= '1;
            sync_b  <= '1;
            deb_lvl <= '1;
            press   <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            press  <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i] <= sync_b[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= ~sync_b[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef CNT_AUTOSTOP_EN
    localparam int TW = $clog2(MAX_TICKS + 1);
    logic [TW-1:0] tick_cnt;

    // Counts on the same edge that registers tick_en_out so back-to-back strobes stay exact.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_cnt <= '0;
        end else if (press[BTN_CLR]) begin
            tick_cnt <= '0;
        end else if (tick_d) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign last_tick = (tick_cnt == TW'(MAX_TICKS - 1));
`else
    assign last_tick = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;

        if (one_sec_flag && (state_q == S_RUN) && !press[BTN_CLR]) begin
            tick_d = 1'b1;
        end

        // Clear wins over everything; reaching the tick limit wins over start/stop.
        if (press[BTN_CLR]) begin
            state_d = S_IDLE;
        end else if (tick_d && last_tick) begin
            state_d = S_DONE;
        end else if (press[BTN_SS]) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            tick_en_out <= 1'b0;
            clr_out     <= 1'b0;
            dir_out     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_en_out <= tick_d;
            clr_out     <= press[BTN_CLR];
            if (press[BTN_DIR]) begin
                dir_out <= ~dir_out;
            end
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// tb/tb_cnt_run_ctrl.sv - directed self-checking bench for cnt_run_ctrl
module tb_cnt_run_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       btn_ss_n = 1'b1;
    logic       btn_clr_n = 1'b1;
    logic       btn_dir_n = 1'b1;
    logic       one_sec_flag = 1'b0;
    logic       tick_en_out;
    logic       clr_out;
    logic       dir_out;
    logic [1:0] state_out;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_tick = 0;
    int n_clr = 0;
    int n_both = 0;
    int chg_cyc = 0;
    logic [1:0] prev_state = 2'b00;

    int t0;
    int tk;
    int cl;

    always #5 clk = ~clk;

    cnt_run_ctrl #(
        .FREQUENCY   (10000),
        .DEBOUNCE_MS (1),
        .MAX_TICKS   (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .btn_ss_n     (btn_ss_n),
        .btn_clr_n    (btn_clr_n),
        .btn_dir_n    (btn_dir_n),
        .one_sec_flag (one_sec_flag),
        .tick_en_out  (tick_en_out),
        .clr_out      (clr_out),
        .dir_out      (dir_out),
        .state_out    (state_out)
    );

    always @(negedge clk) begin
        cyc++;
        if (n_rst) begin
            if (tick_en_out) n_tick++;
            if (clr_out) n_clr++;
            if (tick_en_out && clr_out) n_both++;
        end
        if (state_out != prev_state) chg_cyc = cyc;
        prev_state = state_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_btn(input int which, input logic val);
        case (which)
            0:       btn_ss_n  = val;
            1:       btn_clr_n = val;
            default: btn_dir_n = val;
        endcase
    endtask

    task automatic push(input int which, input int len, input int settle);
        set_btn(which, 1'b0);
        cycles(len);
        set_btn(which, 1'b1);
        cycles(settle);
    endtask

    task automatic pulse_flag(input logic exp_tick);
        one_sec_flag = 1'b1;
        @(posedge clk);
        #2;
        one_sec_flag = 1'b0;
        @(negedge clk);
        check("tick_after_flag", tick_en_out, exp_tick);
        @(negedge clk);
        check("tick_one_cycle", tick_en_out, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #3;
        check("reset_outputs", {tick_en_out, clr_out, dir_out, state_out}, 0);
        cycles(3);
        n_rst = 1'b1;
        cycles(5);
        check("idle_after_reset", state_out, 0);
        check("no_pulse_after_reset", n_tick + n_clr, 0);

        t0 = cyc;
        push(0, 20, 20);
        check("start_run", state_out, 1);
        check("start_latency", ((chg_cyc - t0) >= 11) && ((chg_cyc - t0) <= 14), 1);

        tk = n_tick;
        for (int i = 0; i < 3; i++) begin
            pulse_flag(1'b1);
            cycles(48);
        end
        check("three_ticks", n_tick - tk, 3);

        push(0, 5, 20);
        check("glitch_ignored", state_out, 1);
        push(0, 20, 20);
        check("pause", state_out, 2);
        tk = n_tick;
        pulse_flag(1'b0);
        cycles(10);
        pulse_flag(1'b0);
        check("no_ticks_paused", n_tick - tk, 0);

        push(2, 20, 20);
        check("dir_first", dir_out, 1);
        check("dir_keeps_state", state_out, 2);
        push(2, 20, 20);
        check("dir_second", dir_out, 0);
        check("dir_keeps_state2", state_out, 2);

        push(0, 20, 20);
        check("resume", state_out, 1);
        pulse_flag(1'b1);

        tk = n_tick;
        cl = n_clr;
        btn_ss_n = 1'b0;
        btn_clr_n = 1'b0;
        cycles(12);
        one_sec_flag = 1'b1;
        @(posedge clk);
        #2;
        one_sec_flag = 1'b0;
        @(negedge clk);
        check("prio_clr_pulse", clr_out, 1);
        check("prio_no_tick", tick_en_out, 0);
        check("prio_state", state_out, 0);
        @(posedge clk);
        #2;
        btn_ss_n = 1'b1;
        btn_clr_n = 1'b1;
        cycles(20);
        check("prio_clr_count", n_clr - cl, 1);
        check("prio_tick_count", n_tick - tk, 0);
        check("prio_dir_after_clr", dir_out, 0);

        push(2, 20, 20);
        check("dir_in_idle", dir_out, 1);
        cl = n_clr;
        push(1, 20, 20);
        check("clr_in_idle", n_clr - cl, 1);
        check("dir_survives_clr", dir_out, 1);
        check("idle_after_clr", state_out, 0);

        push(0, 20, 20);
        check("run_before_reset", state_out, 1);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("async_reset_state", state_out, 0);
        check("async_reset_dir", dir_out, 0);
        cycles(2);
        tk = n_tick;
        cl = n_clr;
        n_rst = 1'b1;
        cycles(5);
        check("no_pulse_after_release", (n_tick - tk) + (n_clr - cl), 0);

        cl = n_clr;
        btn_clr_n = 1'b0;
        cycles(12);
        #1;
        n_rst = 1'b0;
        #1;
        check("reset_kills_clr", clr_out, 0);
        btn_clr_n = 1'b1;
        cycles(2);
        n_rst = 1'b1;
        cycles(20);
        check("aborted_clr_count", n_clr - cl, 0);
        check("idle_after_abort", state_out, 0);

`ifdef CNT_AUTOSTOP_EN
        push(0, 20, 20);
        check("auto_run", state_out, 1);
        tk = n_tick;
        for (int i = 0; i < 4; i++) begin
            pulse_flag(1'b1);
            cycles(5);
        end
        check("auto_done", state_out, 3);
        pulse_flag(1'b0);
        pulse_flag(1'b0);
        check("auto_four_ticks", n_tick - tk, 4);
        push(0, 20, 20);
        check("auto_ss_ignored", state_out, 3);
        push(1, 20, 20);
        check("auto_clr_idle", state_out, 0);
        push(0, 20, 20);
        check("auto_rerun", state_out, 1);
        for (int i = 0; i < 3; i++) begin
            pulse_flag(1'b1);
            cycles(5);
        end
        check("auto_restart_count", state_out, 1);
        pulse_flag(1'b1);
        check("auto_done_again", state_out, 3);
`endif

        check("never_tick_and_clr", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
